mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-ported data memory between the CPU load/store path and a secondary requester such as a program loader or debug port. Sits between `cpu`/`Memorytop`-side requesters and the data RAM. Runs a round-robin grant with valid/ready request handshakes and a sequenced issue/response FSM. Each response is returned only to the port that issued the request.

## Interface
- `WIDTH`, 32, data width
- `ADDR_WIDTH`, 32, byte address width
- `CLK` in 1: the single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `reqN_valid` in 1 (N=0,1): request present.
- `reqN_ready` out 1: arbiter accepts the request this cycle.
- `reqN_we` in 1: 1 = store, 0 = load.
- `reqN_addr` in ADDR_WIDTH: byte address.
- `reqN_wdata` in WIDTH: store data.
- `reqN_type` in 3: funct3 access type (byte/half/word, signed/unsigned), passed through unchanged.
- `rspN_valid` out 1: one-cycle completion pulse, for both loads and stores.
- `rspN_rdata` out WIDTH: load data. 0 when `rspN_valid`=0, and 0 for stores.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_WIDTH: memory address.
- `mem_wdata` out WIDTH: memory write data.
- `mem_type` out 3: memory access type.
- `mem_rdata` in WIDTH: memory read data, valid the cycle after `mem_en` (synchronous read).

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - Winner = the valid port, or, if both are valid, the port indicated by `rr_ptr`.
  - `reqW_ready`=1 combinationally for the winner only. The loser's ready is 0.
  - Ready never depends on the same-cycle handshake of the other port.
  - Handshake (`valid && ready`): latch we/addr/wdata/type and the owner id, go to ISSUE, set `rr_ptr` = the other port.
  - No valid request: stay in IDLE and leave `rr_ptr` unchanged.
- **ISSUE**
  - Drive `mem_en`=1 and `mem_we`/`mem_addr`/`mem_wdata`/`mem_type` from the latched registers.
  - Always go to RESP.
- **RESP**
  - `rsp<owner>_valid`=1.
  - `rsp<owner>_rdata` = `mem_rdata` for a load, 0 for a store.
  - Always go to IDLE.
- Outside ISSUE, `mem_en`=`mem_we`=0 and the mem_* data fields are 0.
- Both ready signals are 0 in ISSUE and RESP. A requester holds valid and its fields stable until ready.
- Dropping valid before the handshake is allowed and cancels the request with no side effects.
- Starvation bound: a continuously valid port is granted within 2 arbitration rounds.

## Timing
- Handshake in cycle T, `mem_en` in T+1, `rsp_valid` in T+2, next ready possible in T+3.
- Peak throughput is 1 access per 3 cycles.
- Reset values:
  - state = IDLE, `rr_ptr` = 0 (port 0 preferred).
  - All outputs 0, except `reqN_ready`, which follows the IDLE rule in the first cycle after reset.
- Reset in ISSUE: the memory access already strobed that cycle completes at the memory. No response is produced. The FSM is in IDLE the next cycle.
- Reset in RESP: the response pulse is still visible in that cycle, since it is combinational from state. It is gone after the edge.
- Simultaneous valid on both ports in IDLE: exactly one handshake. The other port is served in the next IDLE.
- Same-address store and load in consecutive grants: the load returns the newly stored data, because the requests are strictly serialised.

## Configuration
- `MEM_ARB_STATS_EN` defined:
  - Adds outputs `grant0_cnt` and `grant1_cnt` [31:0], which count handshakes per port.
  - Both counters are 0 on reset and wrap at 2^32.
  - Both counters increment only on their own port's handshake cycle.
- `MEM_ARB_STATS_EN` undefined:
  - These ports and counters do not exist.
  - All other behaviour is identical.

## Structure
- Shared package `mem_arb_pkg` holds:
  - State enum `arb_state_t` {IDLE, ISSUE, RESP}.
  - Struct `mem_req_t` {we, addr, wdata, type}.
  - Port-id localparams `PORT_CPU`=0 and `PORT_AUX`=1.
- One sub-module `rr_picker`: combinational 2-way round-robin winner select from the valid bits and `rr_ptr`. The FSM, latches and counters stay in `mem_arbiter`.

## Test plan
- **Single load:** `req0` load addr 0x100 with memory word 0xDEADBEEF.
  - `mem_en` at T+1 with addr 0x100.
  - `rsp0_valid` at T+2 with `rdata` 0xDEADBEEF.
  - `rsp1_valid` stays 0.
- **Contention:** both ports valid from reset, port 0 store 0x11 to 0x4, port 1 load 0x4.
  - Port 0 is granted first.
  - Port 1 is granted 3 cycles later and returns 0x11.
- **Round robin:** both ports held valid for 12 cycles.
  - Grants alternate 0,1,0,1.
  - Handshakes land at cycles 0, 3, 6, 9.
- **Store ack:** `req1` store.
  - `rsp1_valid` pulse at T+2 with `rsp1_rdata`=0.
  - `mem_we`=1 only at T+1.
- **Reset in ISSUE:** assert `rst` during ISSUE.
  - No `rsp` pulse after the edge.
  - State is IDLE and port 0 is ready on the next valid.
- **Stats (`MEM_ARB_STATS_EN` defined):** 5 port-0 and 3 port-1 grants.
  - `grant0_cnt`=5, `grant1_cnt`=3.
  - Both counters are 0 after reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Holds the FSM state enum, the latched request record and the port ids.
package mem_arb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    // acc_type carries the funct3 access type through unchanged
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [2:0]        acc_type;
    } mem_req_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational two-way round-robin winner select.
// A lone valid port always wins; on a tie rr_ptr_i names the winner.
module rr_picker
    import mem_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       rr_ptr_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (valid_i[0] && (!valid_i[1] || rr_ptr_i == PORT_CPU)) begin
            grant_o[0] = 1'b1;
        end
        if (valid_i[1] && (!valid_i[0] || rr_ptr_i == PORT_AUX)) begin
            grant_o[1] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous-read data memory (IDLE -> ISSUE -> RESP).
// Define MEM_ARB_STATS_EN to add per-port handshake counters grant0_cnt/grant1_cnt.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH      = DATA_W,
    parameter int ADDR_WIDTH = ADDR_W
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [WIDTH-1:0]      req0_wdata,
    input  logic [2:0]            req0_type,
    output logic                  rsp0_valid,
    output logic [WIDTH-1:0]      rsp0_rdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [WIDTH-1:0]      req1_wdata,
    input  logic [2:0]            req1_type,
    output logic                  rsp1_valid,
    output logic [WIDTH-1:0]      rsp1_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic [2:0]            mem_type,
    input  logic [WIDTH-1:0]      mem_rdata,
`ifdef MEM_ARB_STATS_EN
    output logic [31:0]           grant0_cnt,
    output logic [31:0]           grant1_cnt,
`endif
    output logic [1:0]            dbg_state_o
);

    arb_state_t state_q, state_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic       owner_q, owner_d;
    mem_req_t   req_q, req_d;
    logic [1:0] grant;
    logic       hs0, hs1;

    rr_picker u_picker (
        .valid_i  ({req1_valid, req0_valid}),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (grant)
    );

    // Handshake: a request transfers in the cycle where valid && ready are both 1.
    // Ready is raised only in IDLE, only for the picker's winner, and never
    // depends on the other port's ready; requesters hold fields stable until then.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        req_d      = req_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        hs0        = 1'b0;
        hs1        = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_type   = '0;
        rsp0_valid = 1'b0;
        rsp0_rdata = '0;
        rsp1_valid = 1'b0;
        rsp1_rdata = '0;
        case (state_q)
            IDLE: begin
                req0_ready = grant[0];
                req1_ready = grant[1];
                hs0        = req0_valid && grant[0];
                hs1        = req1_valid && grant[1];
                if (hs0) begin
                    req_d    = '{we: req0_we, addr: ADDR_W'(req0_addr),
                                 wdata: DATA_W'(req0_wdata), acc_type: req0_type};
                    owner_d  = PORT_CPU;
                    rr_ptr_d = PORT_AUX;
                    state_d  = ISSUE;
                end else if (hs1) begin
                    req_d    = '{we: req1_we, addr: ADDR_W'(req1_addr),
                                 wdata: DATA_W'(req1_wdata), acc_type: req1_type};
                    owner_d  = PORT_AUX;
                    rr_ptr_d = PORT_CPU;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = req_q.we;
                mem_addr  = ADDR_WIDTH'(req_q.addr);
                mem_wdata = WIDTH'(req_q.wdata);
                mem_type  = req_q.acc_type;
                state_d   = RESP;
            end
            RESP: begin
                if (owner_q == PORT_CPU) begin
                    rsp0_valid = 1'b1;
                    rsp0_rdata = req_q.we ? '0 : mem_rdata;
                end else begin
                    rsp1_valid = 1'b1;
                    rsp1_rdata = req_q.we ? '0 : mem_rdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= PORT_CPU;
            owner_q  <= PORT_CPU;
            req_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            req_q    <= req_d;
        end
    end

    assign dbg_state_o = state_q;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] grant0_cnt_q, grant1_cnt_q;

    always_ff @(posedge CLK) begin
        if (rst) begin
            grant0_cnt_q <= '0;
            grant1_cnt_q <= '0;
        end else begin
            if (hs0) grant0_cnt_q <= grant0_cnt_q + 32'd1;
            if (hs1) grant1_cnt_q <= grant1_cnt_q + 32'd1;
        end
    end

    assign grant0_cnt = grant0_cnt_q;
    assign grant1_cnt = grant1_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// checked each cycle against a transaction-timing reference model (MEM_ARB_STATS_EN aware).
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  typ;
  } tb_req_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req0_valid, req0_ready, req0_we, rsp0_valid;
  logic [31:0] req0_addr, req0_wdata, rsp0_rdata;
  logic [2:0]  req0_type;
  logic        req1_valid, req1_ready, req1_we, rsp1_valid;
  logic [31:0] req1_addr, req1_wdata, rsp1_rdata;
  logic [2:0]  req1_type;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_type;
  logic [1:0]  dbg_state;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] grant0_cnt, grant1_cnt;
`endif

  mem_arbiter dut (
    .CLK(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_type(req0_type),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_type(req1_type),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_type(mem_type), .mem_rdata(mem_rdata),
`ifdef MEM_ARB_STATS_EN
    .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt),
`endif
    .dbg_state_o(dbg_state)
  );

  // requester state driven by tasks
  logic    v0 = 1'b0, v1 = 1'b0;
  tb_req_t cur0 = '0, cur1 = '0;
  tb_req_t q0[$], q1[$];
  logic    hs0 = 1'b0, hs1 = 1'b0;
  logic    rnd_mode = 1'b0;

  assign req0_valid = v0;
  assign req0_we    = cur0.we;
  assign req0_addr  = cur0.addr;
  assign req0_wdata = cur0.wdata;
  assign req0_type  = cur0.typ;
  assign req1_valid = v1;
  assign req1_we    = cur1.we;
  assign req1_addr  = cur1.addr;
  assign req1_wdata = cur1.wdata;
  assign req1_type  = cur1.typ;

  // behavioural data memory (synchronous read) seen by the DUT
  logic [31:0] ref_mem[256];
  logic [31:0] dut_mem[256];
  logic        sync_mem = 1'b0;

  always @(posedge clk) begin
    if (sync_mem) begin
      for (int i = 0; i < 256; i++) dut_mem[i] <= ref_mem[i];
    end else if (mem_en && mem_we) begin
      dut_mem[mem_addr[9:2]] <= mem_wdata;
    end
    mem_rdata <= (mem_en && !mem_we) ? dut_mem[mem_addr[9:2]] : $urandom;
  end

  // scoreboard
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  int          cyc, last_cyc;
  logic        rr, owner;
  tb_req_t     txn;
  int          gcnt0 = 0, gcnt1 = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic tb_req_t rand_req();
    tb_req_t r;
    r.we    = 1'($urandom_range(0, 1));
    r.addr  = 32'($urandom_range(0, 31)) << 2;
    r.wdata = $urandom;
    r.typ   = 3'($urandom_range(0, 7));
    return r;
  endfunction

  task automatic model_reset();
    cyc      = 0;
    last_cyc = -10;
    rr       = 1'b0;
    owner    = 1'b0;
    txn      = '0;
    gcnt0    = 0;
    gcnt1    = 0;
    hs0      = 1'b0;
    hs1      = 1'b0;
    exp_q.delete();
  endtask

  // driver: hold a request until its handshake; random mode may cancel or add
  task automatic drive();
    logic drop0, drop1;
    drop0 = v0 && !hs0 && rnd_mode && ($urandom_range(0, 9) == 0);
    drop1 = v1 && !hs1 && rnd_mode && ($urandom_range(0, 9) == 0);
    if (hs0 || drop0) v0 = 1'b0;
    if (hs1 || drop1) v1 = 1'b0;
    if (!v0 && !drop0) begin
      if (rnd_mode && q0.size() == 0 && $urandom_range(0, 2) == 0) q0.push_back(rand_req());
      if (q0.size() > 0) begin cur0 = q0.pop_front(); v0 = 1'b1; end
    end
    if (!v1 && !drop1) begin
      if (rnd_mode && q1.size() == 0 && $urandom_range(0, 2) == 0) q1.push_back(rand_req());
      if (q1.size() > 0) begin cur1 = q1.pop_front(); v1 = 1'b1; end
    end
  endtask

  // reference model: a grant at cycle G strobes memory at G+1, responds at G+2,
  // and the arbiter may grant again from G+3; loads see all earlier-granted stores
  task automatic model_step();
    logic        free, e_r0, e_r1, issue, resp, r0, r1;
    logic [31:0] e_rd;
    free  = (cyc >= last_cyc + 3);
    e_r0  = free && v0 && (!v1 || rr == 1'b0);
    e_r1  = free && v1 && (!v0 || rr == 1'b1);
    issue = (cyc == last_cyc + 1);
    resp  = (cyc == last_cyc + 2);
    check_eq("req0_ready", req0_ready, e_r0);
    check_eq("req1_ready", req1_ready, e_r1);
    check_eq("mem_en", mem_en, issue);
    check_eq("mem_we", mem_we, issue && txn.we);
    check_eq("mem_addr", mem_addr, issue ? txn.addr : 32'd0);
    check_eq("mem_wdata", mem_wdata, issue ? txn.wdata : 32'd0);
    check_eq("mem_type", mem_type, issue ? txn.typ : 3'd0);
    e_rd = '0;
    if (resp && exp_q.size() > 0) e_rd = exp_q.pop_front();
    r0 = resp && (owner == 1'b0);
    r1 = resp && (owner == 1'b1);
    check_eq("rsp0_valid", rsp0_valid, r0);
    check_eq("rsp0_rdata", rsp0_rdata, r0 ? e_rd : 32'd0);
    check_eq("rsp1_valid", rsp1_valid, r1);
    check_eq("rsp1_rdata", rsp1_rdata, r1 ? e_rd : 32'd0);
    hs0 = e_r0;
    hs1 = e_r1;
    if (e_r0 || e_r1) begin
      txn      = e_r0 ? cur0 : cur1;
      owner    = e_r1;
      rr       = ~e_r1;
      last_cyc = cyc;
      if (txn.we) begin
        ref_mem[txn.addr[9:2]] = txn.wdata;
        exp_q.push_back(32'd0);
      end else begin
        exp_q.push_back(ref_mem[txn.addr[9:2]]);
      end
      if (e_r0) gcnt0++; else gcnt1++;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  // reset with idle requesters; checks the reset state before release
  task automatic do_reset();
    rst = 1'b1;
    v0  = 1'b0;
    v1  = 1'b0;
    hs0 = 1'b0;
    hs1 = 1'b0;
    q0.delete();
    q1.delete();
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_state", dbg_state, IDLE);
    check_eq("rst_mem_en", mem_en, 1'b0);
    check_eq("rst_rsp0", rsp0_valid, 1'b0);
    check_eq("rst_rsp1", rsp1_valid, 1'b0);
    check_eq("rst_ready0", req0_ready, 1'b0);
`ifdef MEM_ARB_STATS_EN
    check_eq("rst_grant0_cnt", grant0_cnt, 32'd0);
    check_eq("rst_grant1_cnt", grant1_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[64] = 32'hDEADBEEF;
    sync_mem = 1'b1;
    @(posedge clk);
    #1;
    sync_mem = 1'b0;
    do_reset();

    // single load on port 0 from 0x100
    q0.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0, typ: 3'b010});
    run(5);
    // store acknowledged on port 1 with zero rdata
    q1.push_back('{we: 1'b1, addr: 32'h20, wdata: 32'h5A5A1234, typ: 3'b010});
    run(5);

    // contention from reset: store then dependent load
    do_reset();
    q0.push_back('{we: 1'b1, addr: 32'h4, wdata: 32'h11, typ: 3'b010});
    q1.push_back('{we: 1'b0, addr: 32'h4, wdata: 32'h0, typ: 3'b010});
    run(8);

    // both ports held valid: alternating grants
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(rand_req());
      q1.push_back(rand_req());
    end
    run(12);
    run(15);

    // reset asserted while the memory access is being issued
    do_reset();
    q0.push_back('{we: 1'b1, addr: 32'h40, wdata: 32'hCAFE0001, typ: 3'b010});
    run(1);
    drive();
    @(negedge clk);
    model_step();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_issue_rsp0", rsp0_valid, 1'b0);
    check_eq("rst_issue_rsp1", rsp1_valid, 1'b0);
    check_eq("rst_issue_mem_en", mem_en, 1'b0);
    check_eq("rst_issue_state", dbg_state, IDLE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    q0.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0, typ: 3'b010});
    q1.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0, typ: 3'b100});
    run(8);

    // randomized traffic, then drain
    do_reset();
    rnd_mode = 1'b1;
    run(3000);
    rnd_mode = 1'b0;
    run(12);
`ifdef MEM_ARB_STATS_EN
    @(negedge clk);
    check_eq("grant0_cnt", grant0_cnt, 32'(gcnt0));
    check_eq("grant1_cnt", grant1_cnt, 32'(gcnt1));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
